sd_cmd_sequencer: RTL and testbench
===================================

// Module: sd_cmd_sequencer
// PURPOSE
//  Issues one SPI-mode SD command frame and collects its R1 response.
//  Sequence: assert chip select, shift the 48-bit command out on MOSI, poll MISO for the response start bit, capture R1, release the bus.
//  Sits between the SD init/block-transfer FSMs (requesters) and the card pins; one bit moves per clock (the SPI SCLK divider lives outside).
// PARAMETERS
//  NCR_MAX   8  max response-poll length in bytes (polling window = NCR_MAX*8 bit cycles)
//  PRE_BITS  8  idle '1' bits driven with cs_n low before the frame
//  POST_BITS 8  idle '1' bits driven after R1, before cs_n is released
// PORTS
//  clock         in   1   bit clock, rising edge
//  reset         in   1   asynchronous, active-high
//  cmd_valid     in   1   command request
//  cmd_ready     out  1   high only in IDLE; transfer on cmd_valid && cmd_ready
//  cmd_index     in   6   command number (CMD0..CMD63)
//  cmd_arg       in   32  command argument
//  cmd_crc       in   7   CRC7 of {2'b01,cmd_index,cmd_arg}
//  SDin          in   1   MISO from card
//  SDout         out  1   MOSI to card
//  cs_n          out  1   card chip select, active-low
//  busy          out  1   high in every state except IDLE
//  resp_valid    out  1   one-cycle pulse in DONE
//  resp          out  8   R1 byte; holds its value until the next accept
//  resp_timeout  out  1   set with resp_valid when no start bit is seen; holds until the next accept
// BEHAVIOUR
//  Reset (async): state=IDLE, SDout=1, cs_n=1, busy=0, resp_valid=0, resp=8'hFF, resp_timeout=0, all counters 0.
//  Inputs are latched on accept and are don't-care afterwards.
//  Frame, MSB first: {2'b01, cmd_index, cmd_arg, crc7, 1'b1}.
//  States:
//   IDLE: cs_n=1, SDout=1; on accept -> PRE.
//   PRE: cs_n=0, SDout=1 for PRE_BITS cycles -> CMD.
//   CMD: 48 cycles; cycle i drives SDout=frame[47-i] -> WAIT.
//   WAIT: SDout=1; SDin is sampled every cycle for up to NCR_MAX*8 cycles.
//    First SDin==0 -> resp[7]=0 and go to RESP.
//    A start bit on the final poll cycle still counts as found.
//    Window exhausted -> resp=8'hFF, resp_timeout=1, go to POST.
//   RESP: 7 cycles shifting SDin into resp[6:0], MSB first -> POST.
//   POST: SDout=1, cs_n=0 for POST_BITS cycles -> DONE.
//   DONE: cs_n=1, resp_valid=1 for one cycle -> IDLE.
//  Latency, accept to resp_valid: PRE_BITS+48+(k+1)+7+POST_BITS+1 cycles, where k = poll cycles before the start bit.
//  cmd_valid while busy is ignored. It is not queued, and the latched command is unaffected.
//  On accept, resp_timeout clears and resp is set to 8'hFF.
//  Reset mid-frame: cs_n and SDout return to 1 immediately; the frame is abandoned and no resp_valid pulse is produced.
//  Counters are sized $clog2 of their maximum; no wrap occurs inside any state.
// CONFIGURATION
//  SD_CRC7_GEN_EN defined: crc7 is computed internally from the latched {2'b01,index,arg} during CMD (serial LFSR, x^7+x^3+1); cmd_crc is ignored.
//  SD_CRC7_GEN_EN undefined: crc7 = latched cmd_crc; no CRC logic is built.
// STRUCTURE
//  Shared package sd_pkg:
//   - state encoding localparams (IDLE,PRE,CMD,WAIT,RESP,POST,DONE)
//   - CMD_FRAME_BITS=48, R1_BITS=8
//   - command constants CMD0=6'd0, CMD8=6'd8, CMD55=6'd55, ACMD41=6'd41
//  One sub-module, sd_crc7: serial CRC7 with clear/shift-enable, instantiated only under SD_CRC7_GEN_EN.
//  The MOSI shifter, poll counter and R1 capture stay in this module.
// TESTING
//  1. CMD0, arg 0, crc 7'h4A; card returns 8'h01 after 16 idle bits
//     -> MOSI frame is 48'h40_0000_0000_95; resp=8'h01, resp_timeout=0, one resp_valid pulse, cs_n=1 after DONE.
//  2. CMD8, arg 32'h1AA, SDin held 1
//     -> after NCR_MAX*8 poll cycles: resp=8'hFF, resp_timeout=1, POST still runs, cs_n released.
//  3. Start bit on the last poll cycle, response byte 8'h05 -> resp=8'h05, resp_timeout=0.
//  4. cmd_valid held high through a transfer with cmd_index changed mid-frame
//     -> the original frame is sent unchanged; the next command is accepted only in the cycle after DONE.
//  5. reset asserted in the middle of CMD -> cs_n=1, SDout=1 in the same cycle; no resp_valid; the next command completes normally.
//  6. With SD_CRC7_GEN_EN: CMD8 arg 32'h1AA, cmd_crc=0 -> frame ends in byte 8'h87 (crc7=7'h43).

Source files
------------

// File: rtl/sd_pkg.sv
// Shared definitions for the SPI-mode SD command path: state encoding,
// frame geometry, common command numbers and a frame-assembly helper.
// Optional feature macro used by users of this package: SD_CRC7_GEN_EN.
package sd_pkg;

  // State encoding for the command sequencer
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_CMD  = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;
  localparam logic [2:0] ST_POST = 3'd5;
  localparam logic [2:0] ST_DONE = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_PRE  = ST_PRE,
    S_CMD  = ST_CMD,
    S_WAIT = ST_WAIT,
    S_RESP = ST_RESP,
    S_POST = ST_POST,
    S_DONE = ST_DONE
  } sd_state_t;

  // Frame geometry
  localparam int CMD_FRAME_BITS = 48;
  localparam int R1_BITS        = 8;
  // Bits covered by CRC7: {2'b01, index, arg}
  localparam int CRC_DATA_BITS  = 40;

  // Frequently used command numbers
  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] ACMD41 = 6'd41;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Full 48-bit command frame, MSB transmitted first
  function automatic logic [47:0] build_frame(input logic [5:0]  idx,
                                              input logic [31:0] arg,
                                              input logic [6:0]  crc);
    return {2'b01, idx, arg, crc, 1'b1};
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1) over an MSB-first bit stream.
// clear zeroes the remainder; shift folds one bit of din per clock.
// Only instantiated when SD_CRC7_GEN_EN is defined.
module sd_crc7 (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       shift,
  input  logic       din,
  output logic [6:0] crc
);

  logic fb;
  assign fb = din ^ crc[6];

  // LFSR remainder update: feedback enters bit 0 and is xored into bit 3
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      crc <= 7'd0;
    end else if (clear) begin
      crc <= 7'd0;
    end else if (shift) begin
      crc <= {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
  end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// Issues one SPI-mode SD command frame (cs_n, pre-idle, 48-bit frame, R1 poll,
// R1 capture, post-idle, release) and reports the R1 byte or a poll timeout.
// SD_CRC7_GEN_EN: when defined, crc7 is generated internally and cmd_crc is ignored.
module sd_cmd_sequencer
  import sd_pkg::*;
#(
  parameter int NCR_MAX   = 8,
  parameter int PRE_BITS  = 8,
  parameter int POST_BITS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  input  logic        SDin,
  output logic        SDout,
  output logic        cs_n,
  output logic        busy,
  output logic        resp_valid,
  output logic [7:0]  resp,
  output logic        resp_timeout
);

  localparam int POLL_BITS = NCR_MAX * 8;
  localparam int CNT_MAX   = max_int(max_int(PRE_BITS, POST_BITS),
                                     max_int(CMD_FRAME_BITS, POLL_BITS));
  localparam int CNT_W     = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_BITS - 1);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_BITS - 1);
  localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(R1_BITS - 2);
  localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_BITS - 1);

  sd_state_t        state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [47:0]      frame_q;
  logic             accept;
  logic             cmd_bit;
  logic [6:0]       crc_field;

`ifdef SD_CRC7_GEN_EN
  // The latched frame carries a zero CRC field; bits 40..46 of the frame
  // are taken from the CRC engine, which has consumed bits 0..39 by then.
  logic [6:0] crc_val;
  logic       crc_shift;
  logic [2:0] crc_idx;

  assign crc_field = 7'd0;
  assign crc_shift = (state == S_CMD) && (cnt < CNT_W'(CRC_DATA_BITS));
  assign crc_idx   = 3'(CNT_W'(CMD_FRAME_BITS - 2) - cnt);
  assign cmd_bit   = (cnt >= CNT_W'(CRC_DATA_BITS) && cnt < CMD_LAST)
                     ? crc_val[crc_idx] : frame_q[47];

  sd_crc7 u_crc7 (
    .clock (clock),
    .reset (reset),
    .clear (accept),
    .shift (crc_shift),
    .din   (frame_q[47]),
    .crc   (crc_val)
  );
`else
  assign crc_field = cmd_crc;
  assign cmd_bit   = frame_q[47];
`endif

  // State register; async reset drops cs_n/SDout high immediately via IDLE decode
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state and pin/handshake decode
  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    cs_n       = 1'b0;
    SDout      = 1'b1;
    resp_valid = 1'b0;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        cs_n      = 1'b1;
        accept    = cmd_valid;
        if (cmd_valid) next_state = S_PRE;
      end
      S_PRE:  if (cnt == PRE_LAST) next_state = S_CMD;
      S_CMD: begin
        SDout = cmd_bit;
        if (cnt == CMD_LAST) next_state = S_WAIT;
      end
      S_WAIT: begin
        if (!SDin)                  next_state = S_RESP;
        else if (cnt == POLL_LAST)  next_state = S_POST;
      end
      S_RESP: if (cnt == RESP_LAST) next_state = S_POST;
      S_POST: if (cnt == POST_LAST) next_state = S_DONE;
      S_DONE: begin
        cs_n       = 1'b1;
        resp_valid = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Per-state bit counter: restarts on every state change, never wraps
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                  cnt <= '0;
    else if (next_state != state)               cnt <= '0;
    else if (state != S_IDLE)                   cnt <= cnt + 1'b1;
  end

  // Command latch, MOSI shifter and R1 capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_q      <= '0;
      resp         <= 8'hFF;
      resp_timeout <= 1'b0;
    end else if (accept) begin
      frame_q      <= build_frame(cmd_index, cmd_arg, crc_field);
      resp         <= 8'hFF;
      resp_timeout <= 1'b0;
    end else begin
      case (state)
        S_CMD:  frame_q <= {frame_q[46:0], 1'b1};
        S_WAIT: begin
          if (!SDin) begin
            resp[7] <= 1'b0;
          end else if (cnt == POLL_LAST) begin
            resp         <= 8'hFF;
            resp_timeout <= 1'b1;
          end
        end
        S_RESP: resp[6:0] <= {resp[5:0], SDin};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Self-checking bench for sd_cmd_sequencer: directed card scenarios plus
// randomized commands/response delays against a cycle-timeline card model.
module tb_sd_cmd_sequencer;
  import sd_pkg::*;

  localparam int NCR_MAX   = 8;
  localparam int PRE_BITS  = 8;
  localparam int POST_BITS = 8;
  localparam int POLL      = NCR_MAX * 8;
  // First poll interval (counted from the accept edge)
  localparam int W0        = PRE_BITS + 48 + 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [6:0]  cmd_crc;
  logic        SDin;
  logic        SDout;
  logic        cs_n;
  logic        busy;
  logic        resp_valid;
  logic [7:0]  resp;
  logic        resp_timeout;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [47:0] last_frame;

  sd_cmd_sequencer #(
    .NCR_MAX   (NCR_MAX),
    .PRE_BITS  (PRE_BITS),
    .POST_BITS (POST_BITS)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_index    (cmd_index),
    .cmd_arg      (cmd_arg),
    .cmd_crc      (cmd_crc),
    .SDin         (SDin),
    .SDout        (SDout),
    .cs_n         (cs_n),
    .busy         (busy),
    .resp_valid   (resp_valid),
    .resp         (resp),
    .resp_timeout (resp_timeout)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CRC7 by polynomial long division of msg*x^7 by x^7+x^3+1 (0x89)
  function automatic logic [6:0] crc7_ref(input logic [5:0] idx, input logic [31:0] arg);
    logic [46:0] r;
    r = {2'b01, idx, arg, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  // One command; k = poll cycles before the start bit (k >= POLL means no response)
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input int k,
                         input logic [7:0] rbyte, input bit hold);
    bit          tmo;
    int          done_j;
    logic [47:0] exp_frame;
    logic [7:0]  exp_resp;
    logic [47:0] frame;
    int          e_cs, e_out, e_busy, e_vld, e_rdy;
    tmo       = (k >= POLL);
    done_j    = tmo ? (W0 + POLL + POST_BITS) : (W0 + k + 8 + POST_BITS);
    exp_frame = {2'b01, idx, arg, crc7_ref(idx, arg), 1'b1};
    exp_resp  = tmo ? 8'hFF : rbyte;
    frame = '0; e_cs = 0; e_out = 0; e_busy = 0; e_vld = 0; e_rdy = 0;

    cmd_valid = 1'b1;
    cmd_index = idx;
    cmd_arg   = arg;
`ifdef SD_CRC7_GEN_EN
    cmd_crc   = 7'($urandom);
`else
    cmd_crc   = crc7_ref(idx, arg);
`endif
    SDin      = 1'b1;
    @(negedge clock);
    check("ready_before_accept", cmd_ready, 1);
    @(posedge clock);
    for (int j = 1; j <= done_j + 1; j++) begin
      #1;
      if (!hold) begin
        cmd_valid = 1'b0;
        cmd_index = 6'($urandom);
        cmd_arg   = $urandom;
        cmd_crc   = 7'($urandom);
      end else if (j == PRE_BITS + 10) begin
        cmd_index = ~idx;
        cmd_arg   = ~arg;
      end
      if (tmo)                                 SDin = 1'b1;
      else if (j == W0 + k)                    SDin = 1'b0;
      else if (j > W0 + k && j <= W0 + k + 7)  SDin = rbyte[6 - (j - W0 - k - 1)];
      else                                     SDin = 1'b1;
      @(negedge clock);
      if (cs_n !== ((j < done_j) ? 1'b0 : 1'b1)) e_cs++;
      if (j >= PRE_BITS + 1 && j <= PRE_BITS + 48) frame = {frame[46:0], SDout};
      else if (SDout !== 1'b1) e_out++;
      if (busy !== (j <= done_j)) e_busy++;
      if (resp_valid !== (j == done_j)) e_vld++;
      if (cmd_ready !== (j > done_j)) e_rdy++;
      if (j == done_j) begin
        check("resp", resp, exp_resp);
        check("resp_timeout", resp_timeout, tmo);
      end
      if (j == done_j + 1) check("resp_hold", resp, exp_resp);
      if (j <= done_j) @(posedge clock);
    end
    cmd_valid = 1'b0;
    check("mosi_frame", frame, exp_frame);
    check("cs_n_timeline", e_cs, 0);
    check("sdout_idle_ones", e_out, 0);
    check("busy_timeline", e_busy, 0);
    check("resp_valid_pulse", e_vld, 0);
    check("cmd_ready_timeline", e_rdy, 0);
    last_frame = frame;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n_vld;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_index = '0;
    cmd_arg   = '0;
    cmd_crc   = '0;
    SDin      = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_sdout", SDout, 1);
    check("rst_cs_n", cs_n, 1);
    check("rst_busy", busy, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp", resp, 8'hFF);
    check("rst_timeout", resp_timeout, 0);
    check("rst_ready", cmd_ready, 1);
    @(posedge clock);
    #1 reset = 1'b0;

    // CMD0, response 0x01 after 16 idle bits
    run_cmd(CMD0, 32'h0, 16, 8'h01, 1'b0);
    check("cmd0_frame_literal", last_frame, 48'h40_0000_0000_95);
    // CMD8, card silent -> timeout
    run_cmd(CMD8, 32'h1AA, POLL, 8'hFF, 1'b0);
    // Start bit on the final poll cycle still counts
    run_cmd(CMD55, $urandom, POLL - 1, 8'h05, 1'b0);
    // Start bit on the first poll cycle
    run_cmd(CMD55, 32'h0, 0, 8'h00, 1'b0);
    // cmd_valid held, inputs changed mid-frame
    run_cmd(ACMD41, 32'h4000_0000, 5, 8'h01, 1'b1);
    // CMD8 trailing byte carries crc7 0x43
    run_cmd(CMD8, 32'h1AA, 2, 8'h01, 1'b0);
    check("cmd8_last_byte", last_frame[7:0], 8'h87);

    // Reset in the middle of the command frame
    cmd_valid = 1'b1; cmd_index = CMD0; cmd_arg = 32'h0; cmd_crc = crc7_ref(CMD0, 32'h0);
    @(negedge clock);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    repeat (PRE_BITS + 19) @(posedge clock);
    #1;
    check("mid_cmd_cs_n", cs_n, 0);
    check("mid_cmd_sdout", SDout, 0);
    #2 reset = 1'b1;
    #1;
    check("arst_cs_n", cs_n, 1);
    check("arst_sdout", SDout, 1);
    check("arst_busy", busy, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    n_vld = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clock);
      if (resp_valid) n_vld++;
    end
    check("no_valid_after_reset", n_vld, 0);
    check("resp_after_reset", resp, 8'hFF);
    @(posedge clock);
    #1;
    run_cmd(CMD0, 32'h0, 3, 8'h01, 1'b0);

    // Randomized commands, delays (some past the window) and R1 bytes
    for (int t = 0; t < 10; t++) begin
      run_cmd(6'($urandom), $urandom, int'($urandom_range(0, POLL + 6)),
              8'($urandom_range(0, 127)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
